// File: rtl/pipe_rx_data.sv
// Receive-side PIPE data stage: per-generation width select, registered data/K/sync header,
// and 128b/130b block tracking. Define PIPE_RX_ERR_CNT_EN to add the saturating error counter.
module pipe_rx_data #(
  parameter int unsigned PIPE_WIDTH_GEN1 = 8,
  parameter int unsigned PIPE_WIDTH_GEN2 = 8,
  parameter int unsigned PIPE_WIDTH_GEN3 = 16,
  parameter int unsigned PIPE_WIDTH_GEN4 = 32,
  parameter int unsigned PIPE_WIDTH_GEN5 = 32
) (
  input  logic        pclk,
  input  logic        reset_n,
  input  logic [2:0]  generation,
  input  logic [31:0] RxData,
  input  logic [3:0]  RxDataK,
  input  logic        RxDataValid,
  input  logic        RxStartBlock,
  input  logic [1:0]  RxSyncHeader,
  input  logic        RxValid,
  output logic [31:0] rxDataOut,
  output logic [3:0]  rxDataK,
  output logic        rxDataValid,
  output logic [1:0]  rxSyncHeader,
  output logic        rxBlockStart,
  output logic        rxBlockEnd,
  output logic        rxSyncHdrErr,
  output logic        rxAlignErr,
  output logic        rxLocked
`ifdef PIPE_RX_ERR_CNT_EN
  ,
  input  logic        rxErrCountClr,
  output logic [7:0]  rxErrCount
`endif
);

  localparam int unsigned DW = 32;
  localparam int unsigned KW = 4;
  localparam int unsigned CW = 4;
  localparam int unsigned WW = 6;

  localparam logic [CW-1:0] LAST_GEN3 = CW'(128 / PIPE_WIDTH_GEN3 - 1);
  localparam logic [CW-1:0] LAST_GEN4 = CW'(128 / PIPE_WIDTH_GEN4 - 1);
  localparam logic [CW-1:0] LAST_GEN5 = CW'(128 / PIPE_WIDTH_GEN5 - 1);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_e;

  state_e          state_q, state_d, state_eff;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d, cnt_eff, last_cnt;
  logic [2:0]      gen_q, gen_d;
  logic [DW-1:0]   data_q, data_d, data_mask;
  logic [KW-1:0]   k_q, k_d, k_mask;
  logic            valid_q, valid_d;
  logic [1:0]      hdr_q, hdr_d;
  logic            bstart_q, bstart_d;
  logic            bend_q, bend_d;
  logic            hdr_err_q, hdr_err_d;
  logic            align_err_q, align_err_d;
  logic [WW-1:0]   w_sel;
  logic            gen_ok, gen_legacy, gen_chg, hdr_bad;

  // Per-generation width and last-beat index of a 128-bit block
  always_comb begin
    w_sel    = WW'(DW);
    last_cnt = '0;
    case (generation)
      3'd1: w_sel = WW'(PIPE_WIDTH_GEN1);
      3'd2: w_sel = WW'(PIPE_WIDTH_GEN2);
      3'd3: begin w_sel = WW'(PIPE_WIDTH_GEN3); last_cnt = LAST_GEN3; end
      3'd4: begin w_sel = WW'(PIPE_WIDTH_GEN4); last_cnt = LAST_GEN4; end
      3'd5: begin w_sel = WW'(PIPE_WIDTH_GEN5); last_cnt = LAST_GEN5; end
      default: ;
    endcase
  end

  assign data_mask  = {DW{1'b1}} >> (WW'(DW) - w_sel);
  assign k_mask     = {KW{1'b1}} >> (3'd4 - w_sel[5:3]);
  assign gen_ok     = (generation >= 3'd1) && (generation <= 3'd5);
  assign gen_legacy = (generation == 3'd1) || (generation == 3'd2);
  assign gen_chg    = (generation != gen_q);
  assign hdr_bad    = (RxSyncHeader == 2'b00) || (RxSyncHeader == 2'b11);
  // A generation change restarts block tracking on the same cycle
  assign state_eff  = gen_chg ? UNLOCKED : state_q;
  assign cnt_eff    = gen_chg ? '0 : beat_cnt_q;

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    gen_d       = generation;
    data_d      = data_q;
    k_d         = k_q;
    valid_d     = 1'b0;
    hdr_d       = hdr_q;
    bstart_d    = 1'b0;
    bend_d      = 1'b0;
    hdr_err_d   = 1'b0;
    align_err_d = 1'b0;

    if (!gen_ok) begin
      state_d    = UNLOCKED;
      beat_cnt_d = '0;
      data_d     = '0;
      k_d        = '0;
      hdr_d      = 2'b00;
    end else if (gen_legacy) begin
      state_d    = UNLOCKED;
      beat_cnt_d = '0;
      hdr_d      = 2'b00;
      if (RxValid) begin
        data_d  = RxData & data_mask;
        k_d     = RxDataK & k_mask;
        valid_d = 1'b1;
      end
    end else if (!RxValid) begin
      // Lock loss drops tracking silently
      state_d    = UNLOCKED;
      beat_cnt_d = '0;
    end else begin
      state_d    = state_eff;
      beat_cnt_d = cnt_eff;
      if (RxDataValid) begin
        data_d  = RxData & data_mask;
        k_d     = '0;
        valid_d = 1'b1;
        if (RxStartBlock) begin
          // Any start beat (re)opens a block; unexpected mid-block starts are flagged
          state_d     = LOCKED;
          beat_cnt_d  = CW'(1);
          hdr_d       = RxSyncHeader;
          bstart_d    = 1'b1;
          hdr_err_d   = hdr_bad;
          align_err_d = (state_eff == LOCKED) && (cnt_eff != '0);
        end else if (state_eff == LOCKED) begin
          if (cnt_eff == '0) begin
            align_err_d = 1'b1;
            state_d     = UNLOCKED;
            beat_cnt_d  = '0;
          end else if (cnt_eff == last_cnt) begin
            bend_d     = 1'b1;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = cnt_eff + CW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= UNLOCKED;
      beat_cnt_q  <= '0;
      gen_q       <= '0;
      data_q      <= '0;
      k_q         <= '0;
      valid_q     <= 1'b0;
      hdr_q       <= 2'b00;
      bstart_q    <= 1'b0;
      bend_q      <= 1'b0;
      hdr_err_q   <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      gen_q       <= gen_d;
      data_q      <= data_d;
      k_q         <= k_d;
      valid_q     <= valid_d;
      hdr_q       <= hdr_d;
      bstart_q    <= bstart_d;
      bend_q      <= bend_d;
      hdr_err_q   <= hdr_err_d;
      align_err_q <= align_err_d;
    end
  end

  assign rxDataOut    = data_q;
  assign rxDataK      = k_q;
  assign rxDataValid  = valid_q;
  assign rxSyncHeader = hdr_q;
  assign rxBlockStart = bstart_q;
  assign rxBlockEnd   = bend_q;
  assign rxSyncHdrErr = hdr_err_q;
  assign rxAlignErr   = align_err_q;
  assign rxLocked     = (state_q == LOCKED);

`ifdef PIPE_RX_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;
  logic [8:0] err_sum;

  // Saturating count of error pulses; clear wins over increment
  always_comb begin
    err_sum   = 9'(err_cnt_q) + 9'(hdr_err_d) + 9'(align_err_d);
    err_cnt_d = (err_sum > 9'd255) ? 8'hFF : err_sum[7:0];
    if (rxErrCountClr) err_cnt_d = 8'h00;
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) err_cnt_q <= 8'h00;
    else          err_cnt_q <= err_cnt_d;
  end

  assign rxErrCount = err_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_rx_data.sv
// Scoreboard bench for pipe_rx_data: stimulus pushes expected outputs, a negedge monitor checks them.
// Define PIPE_RX_ERR_CNT_EN to also exercise the error counter.
module tb_pipe_rx_data;

  logic        pclk = 1'b0;
  logic        reset_n;
  logic [2:0]  generation;
  logic [31:0] RxData;
  logic [3:0]  RxDataK;
  logic        RxDataValid, RxStartBlock, RxValid;
  logic [1:0]  RxSyncHeader;
  logic [31:0] rxDataOut;
  logic [3:0]  rxDataK;
  logic        rxDataValid, rxBlockStart, rxBlockEnd, rxSyncHdrErr, rxAlignErr, rxLocked;
  logic [1:0]  rxSyncHeader;
  logic        rxErrCountClr;
  logic [7:0]  rxErrCount;

  pipe_rx_data dut (
    .pclk(pclk), .reset_n(reset_n), .generation(generation),
    .RxData(RxData), .RxDataK(RxDataK), .RxDataValid(RxDataValid),
    .RxStartBlock(RxStartBlock), .RxSyncHeader(RxSyncHeader), .RxValid(RxValid),
    .rxDataOut(rxDataOut), .rxDataK(rxDataK), .rxDataValid(rxDataValid),
    .rxSyncHeader(rxSyncHeader), .rxBlockStart(rxBlockStart), .rxBlockEnd(rxBlockEnd),
    .rxSyncHdrErr(rxSyncHdrErr), .rxAlignErr(rxAlignErr), .rxLocked(rxLocked)
`ifdef PIPE_RX_ERR_CNT_EN
    , .rxErrCountClr(rxErrCountClr), .rxErrCount(rxErrCount)
`endif
  );

`ifndef PIPE_RX_ERR_CNT_EN
  assign rxErrCount = 8'h00;
`endif

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        v;
    logic [1:0]  hdr;
    logic        bs, be, he, ae, lk;
  } obs_t;

  typedef struct {
    string      name;
    logic       care;
    obs_t       exp;
    logic       care_cnt;
    logic [7:0] cnt;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  localparam obs_t ZERO = '0;

  function automatic obs_t mk(input logic [31:0] d, input logic [3:0] k, input logic v,
                              input logic [1:0] hdr, input logic bs, input logic be,
                              input logic he, input logic ae, input logic lk);
    obs_t o;
    o = '{d: d, k: k, v: v, hdr: hdr, bs: bs, be: be, he: he, ae: ae, lk: lk};
    return o;
  endfunction

  // Monitor: one expected entry per cycle, compared mid-cycle
  always @(negedge pclk) begin
    exp_t e;
    obs_t a;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = mk(rxDataOut, rxDataK, rxDataValid, rxSyncHeader, rxBlockStart, rxBlockEnd,
             rxSyncHdrErr, rxAlignErr, rxLocked);
      if (e.care) begin
        checks++;
        if (a !== e.exp) begin
          errors++;
          $display("FAIL %s: got d=%h k=%h v=%b hdr=%b bs=%b be=%b he=%b ae=%b lk=%b | want d=%h k=%h v=%b hdr=%b bs=%b be=%b he=%b ae=%b lk=%b",
                   e.name, a.d, a.k, a.v, a.hdr, a.bs, a.be, a.he, a.ae, a.lk,
                   e.exp.d, e.exp.k, e.exp.v, e.exp.hdr, e.exp.bs, e.exp.be, e.exp.he, e.exp.ae, e.exp.lk);
        end
      end
      if (e.care_cnt) begin
        checks++;
        if (rxErrCount !== e.cnt) begin
          errors++;
          $display("FAIL %s: got rxErrCount=%0d want %0d", e.name, rxErrCount, e.cnt);
        end
      end
    end
  end

  task automatic beat_in(input logic [2:0] g, input logic [31:0] d, input logic [3:0] k,
                         input logic rv, input logic dv, input logic sb, input logic [1:0] sh);
    @(negedge pclk);
    #1;
    generation = g; RxData = d; RxDataK = k; RxValid = rv;
    RxDataValid = dv; RxStartBlock = sb; RxSyncHeader = sh;
  endtask

  task automatic expect_o(input string nm, input obs_t e);
    q.push_back('{nm, 1'b1, e, 1'b0, 8'd0});
  endtask

  task automatic expect_cnt(input string nm, input logic [7:0] c);
    q.push_back('{nm, 1'b0, ZERO, 1'b1, c});
  endtask

  task automatic release_reset();
    @(negedge pclk);
    #1;
    generation = 3'd0; RxValid = 1'b0; RxDataValid = 1'b0; RxStartBlock = 1'b0;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; generation = 3'd0; RxData = '0; RxDataK = '0; RxValid = 1'b0;
    RxDataValid = 1'b0; RxStartBlock = 1'b0; RxSyncHeader = 2'b00; rxErrCountClr = 1'b0;

    // Reset holds everything at zero despite active inputs
    repeat (2) begin
      beat_in(3'd1, 32'h1234_5678, 4'hF, 1'b1, 1'b1, 1'b1, 2'b01);
      expect_o("reset_state", ZERO);
    end
    release_reset();

    // Gen1/Gen2 width select
    beat_in(3'd1, 32'hAABB_CCBC, 4'hF, 1'b1, 1'b0, 1'b0, 2'b00);
    expect_o("gen1_data", mk(32'h0000_00BC, 4'h1, 1, 2'b00, 0, 0, 0, 0, 0));
    beat_in(3'd1, 32'h1234_5678, 4'hF, 1'b0, 1'b1, 1'b0, 2'b00);
    expect_o("gen1_hold", mk(32'h0000_00BC, 4'h1, 0, 2'b00, 0, 0, 0, 0, 0));
    beat_in(3'd2, 32'h1122_3344, 4'h2, 1'b1, 1'b1, 1'b1, 2'b01);
    expect_o("gen2_data", mk(32'h0000_0044, 4'h0, 1, 2'b00, 0, 0, 0, 0, 0));

    // Gen3 block with a stall after beat 3
    beat_in(3'd3, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b1, 1'b1, 2'b01);
    expect_o("gen3_start", mk(32'h0000_BEEF, 4'h0, 1, 2'b01, 1, 0, 0, 0, 1));
    for (int i = 2; i <= 8; i++) begin
      if (i == 4) begin
        beat_in(3'd3, 32'h7777_7777, 4'hF, 1'b1, 1'b0, 1'b0, 2'b00);
        expect_o("gen3_stall", mk(32'h0000_0003, 4'h0, 0, 2'b01, 0, 0, 0, 0, 1));
      end
      beat_in(3'd3, {16'hA5A5, 16'(i)}, 4'hF, 1'b1, 1'b1, 1'b0, 2'b00);
      expect_o("gen3_beat", mk({16'h0000, 16'(i)}, 4'h0, 1, 2'b01, 0, (i == 8), 0, 0, 1));
    end

    // Gen3 locked, RxValid drops mid-block
    beat_in(3'd3, 32'hFFFF_0001, 4'h0, 1'b1, 1'b1, 1'b1, 2'b10);
    expect_o("gen3_b2_start", mk(32'h0000_0001, 4'h0, 1, 2'b10, 1, 0, 0, 0, 1));
    beat_in(3'd3, 32'hFFFF_0002, 4'h0, 1'b1, 1'b1, 1'b0, 2'b00);
    expect_o("gen3_b2_mid", mk(32'h0000_0002, 4'h0, 1, 2'b10, 0, 0, 0, 0, 1));
    beat_in(3'd3, 32'hFFFF_0003, 4'h0, 1'b0, 1'b1, 1'b0, 2'b00);
    expect_o("gen3_rxvalid_drop", mk(32'h0000_0002, 4'h0, 0, 2'b10, 0, 0, 0, 0, 0));
    beat_in(3'd3, 32'hFFFF_0005, 4'h0, 1'b1, 1'b1, 1'b0, 2'b00);
    expect_o("gen3_unlocked_fwd", mk(32'h0000_0005, 4'h0, 1, 2'b10, 0, 0, 0, 0, 0));

    // Gen3 locked, generation switches to 4 mid-block
    beat_in(3'd3, 32'hFFFF_0007, 4'h0, 1'b1, 1'b1, 1'b1, 2'b01);
    expect_o("gen3_b3_start", mk(32'h0000_0007, 4'h0, 1, 2'b01, 1, 0, 0, 0, 1));
    beat_in(3'd3, 32'hFFFF_0008, 4'h0, 1'b1, 1'b1, 1'b0, 2'b00);
    expect_o("gen3_b3_mid", mk(32'h0000_0008, 4'h0, 1, 2'b01, 0, 0, 0, 0, 1));
    beat_in(3'd4, 32'hCAFE_F00D, 4'hF, 1'b1, 1'b1, 1'b0, 2'b00);
    expect_o("gen_switch_4", mk(32'hCAFE_F00D, 4'h0, 1, 2'b01, 0, 0, 0, 0, 0));

    // Gen4 back-to-back blocks, second header illegal
    for (int i = 1; i <= 8; i++) begin
      beat_in(3'd4, 32'h4000_0000 + 32'(i), 4'hF, 1'b1, 1'b1, (i == 1 || i == 5),
              (i <= 4) ? 2'b10 : 2'b11);
      expect_o("gen4_beat", mk(32'h4000_0000 + 32'(i), 4'h0, 1, (i <= 4) ? 2'b10 : 2'b11,
                               (i == 1 || i == 5), (i == 4 || i == 8), (i == 5), 0, 1));
    end

    // Gen5 early start resync, then missing start
    beat_in(3'd5, 32'h5000_0001, 4'h0, 1'b1, 1'b1, 1'b1, 2'b01);
    expect_o("gen5_start", mk(32'h5000_0001, 4'h0, 1, 2'b01, 1, 0, 0, 0, 1));
    beat_in(3'd5, 32'h5000_0002, 4'h0, 1'b1, 1'b1, 1'b0, 2'b00);
    expect_o("gen5_cnt1", mk(32'h5000_0002, 4'h0, 1, 2'b01, 0, 0, 0, 0, 1));
    beat_in(3'd5, 32'h5000_0003, 4'h0, 1'b1, 1'b1, 1'b1, 2'b10);
    expect_o("gen5_resync", mk(32'h5000_0003, 4'h0, 1, 2'b10, 1, 0, 0, 1, 1));
    for (int i = 4; i <= 6; i++) begin
      beat_in(3'd5, 32'h5000_0000 + 32'(i), 4'h0, 1'b1, 1'b1, 1'b0, 2'b00);
      expect_o("gen5_after_resync", mk(32'h5000_0000 + 32'(i), 4'h0, 1, 2'b10, 0, (i == 6), 0, 0, 1));
    end
    beat_in(3'd5, 32'h5000_0007, 4'h0, 1'b1, 1'b1, 1'b0, 2'b00);
    expect_o("gen5_missing_start", mk(32'h5000_0007, 4'h0, 1, 2'b10, 0, 0, 0, 1, 0));

    // Idle generation code
    beat_in(3'd6, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b1, 1'b1, 2'b00);
    expect_o("gen_idle", ZERO);

    // Asynchronous reset mid-block, before the next sample point
    beat_in(3'd3, 32'h0000_0009, 4'h0, 1'b1, 1'b1, 1'b1, 2'b01);
    expect_o("rst_pre_start", mk(32'h0000_0009, 4'h0, 1, 2'b01, 1, 0, 0, 0, 1));
    beat_in(3'd3, 32'h0000_000A, 4'h0, 1'b1, 1'b1, 1'b0, 2'b00);
    expect_o("async_reset", ZERO);
    @(posedge pclk);
    #3;
    reset_n = 1'b0;
    beat_in(3'd3, 32'h0000_000B, 4'h0, 1'b1, 1'b1, 1'b1, 2'b01);
    expect_o("reset_held", ZERO);
    release_reset();

`ifdef PIPE_RX_ERR_CNT_EN
    // 300 error events saturate the counter; clear beats a simultaneous error
    beat_in(3'd5, 32'h0, 4'h0, 1'b1, 1'b1, 1'b1, 2'b01);
    for (int i = 1; i <= 150; i++) begin
      beat_in(3'd5, 32'(i), 4'h0, 1'b1, 1'b1, 1'b1, 2'b00);
      if (i == 64) expect_cnt("errcnt_128", 8'd128);
      if (i == 150) expect_cnt("errcnt_sat", 8'd255);
    end
    beat_in(3'd5, 32'h0, 4'h0, 1'b1, 1'b1, 1'b1, 2'b00);
    rxErrCountClr = 1'b1;
    expect_cnt("errcnt_clr", 8'd0);
    beat_in(3'd5, 32'h0, 4'h0, 1'b1, 1'b1, 1'b1, 2'b00);
    rxErrCountClr = 1'b0;
    expect_cnt("errcnt_after_clr", 8'd2);
`endif

    repeat (3) @(negedge pclk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_rx_data.md
Name: pipe_rx_data

Overview:
- Receive-side PIPE data stage, between the PHY PIPE RX interface and the descrambler.
- Selects the active data width for the current generation and registers the received data, K and sync-header fields.
- For Gen3+ (128b/130b), tracks 128-bit block boundaries from RxStartBlock and flags sync-header and block-alignment errors to the descrambler and LTSSM.

Parameters:
- PIPE_WIDTH_GEN1, 8, Gen1 RX data width in bits.
- PIPE_WIDTH_GEN2, 8, Gen2 RX data width in bits.
- PIPE_WIDTH_GEN3, 16, Gen3 RX data width in bits.
- PIPE_WIDTH_GEN4, 32, Gen4 RX data width in bits.
- PIPE_WIDTH_GEN5, 32, Gen5 RX data width in bits.
- All widths are multiples of 8, at most 32, and divide 128.

Ports:
- pclk  in  1  PIPE clock.
- reset_n  in  1  asynchronous, active-low reset.
- generation  in  3  current link speed: 1..5 valid; any other value means idle.
- RxData  in  32  PHY receive data; bits above the active width are ignored.
- RxDataK  in  4  PHY K-character flags, one per byte.
- RxDataValid  in  1  PHY beat qualifier (Gen3+ stall cycles).
- RxStartBlock  in  1  first beat of a 128b/130b block.
- RxSyncHeader  in  2  sync header, valid when RxStartBlock=1.
- RxValid  in  1  PHY symbol/block lock.
- rxDataOut  out  32  width-selected data, zero-extended.
- rxDataK  out  4  width-selected K flags; always 0 for Gen3+.
- rxDataValid  out  1  qualified beat.
- rxSyncHeader  out  2  registered sync header of the current block.
- rxBlockStart  out  1  one-cycle pulse on the first beat of a block.
- rxBlockEnd  out  1  one-cycle pulse on the last beat of a block.
- rxSyncHdrErr  out  1  one-cycle pulse when the start-beat header is 00 or 11.
- rxAlignErr  out  1  one-cycle pulse on a block-boundary mismatch.
- rxLocked  out  1  high while the block tracker is LOCKED.

Behaviour:
- Reset (asynchronous): all outputs 0, FSM=UNLOCKED, beat_cnt=0, gen_q=0.
- Latency: every output is registered, one pclk after its input.
- W = width for the current generation; BPB = 128/W (8 for Gen3, 4 for Gen4/5).
- beat = RxValid & RxDataValid.
- When beat=0:
  - rxDataValid=0; rxDataOut, rxDataK and rxSyncHeader hold their values.
  - beat_cnt does not advance.
  - All pulse outputs are 0.
- Gen1/2:
  - rxDataOut = zero-extended RxData[W-1:0]; rxDataK = RxDataK[W/8-1:0], zero-extended.
  - rxDataValid = RxValid (RxDataValid is ignored).
  - FSM is forced to UNLOCKED; block outputs stay 0.
- Gen3+:
  - Data is forwarded on every beat, locked or not; rxDataK = 0.
- FSM state UNLOCKED:
  - Leaves only on a beat with RxStartBlock=1, going to LOCKED.
  - On that beat: rxBlockStart=1, rxSyncHeader=RxSyncHeader, beat_cnt=1.
  - Beats with RxStartBlock=0 are forwarded with no pulses.
- FSM state LOCKED, evaluated per beat:
  - beat_cnt==0 and RxStartBlock=1: rxBlockStart=1, latch the header, beat_cnt=1.
  - beat_cnt==0 and RxStartBlock=0: rxAlignErr=1, go to UNLOCKED, beat_cnt=0.
  - beat_cnt!=0 and RxStartBlock=1: rxAlignErr=1, resync as a new block start (rxBlockStart=1, beat_cnt=1, stay LOCKED).
  - Otherwise beat_cnt increments.
  - When beat_cnt==BPB-1 on a beat: rxBlockEnd=1, beat_cnt wraps to 0.
- Sync-header check: any start beat with RxSyncHeader ∈ {00,11} gives rxSyncHdrErr=1, in the same cycle as rxBlockStart. Block tracking continues.
- RxValid=0 while LOCKED: go to UNLOCKED and clear beat_cnt, with no error pulse.
- generation changes (generation ≠ gen_q):
  - That cycle is treated as UNLOCKED with beat_cnt=0; gen_q updates.
  - Data of that cycle is forwarded using the new width.
- generation ∉ 1..5: all data and valid outputs are 0, FSM=UNLOCKED.
- Simultaneous events in one beat: alignment-error resync and a sync-header error may pulse together.

Optional Feature:
- Macro: PIPE_RX_ERR_CNT_EN.
- Defined:
  - Adds output rxErrCount[7:0]: a saturating count of rxSyncHdrErr plus rxAlignErr pulses, +2 when both fire in one cycle, saturating at 255.
  - Adds input rxErrCountClr (1 bit), a synchronous clear with priority over increment.
  - Reset value 0.
- Undefined: neither port exists and there is no counter logic.

Test Plan:
- Gen1: RxValid=1, RxData=32'hAABBCCBC, RxDataK=4'hF → next cycle rxDataOut=32'h000000BC, rxDataK=4'h1, rxDataValid=1, rxLocked=0.
- Gen3: start beat with header 2'b01, then 7 beats with RxDataValid=1 and a RxDataValid=0 stall after beat 3 → rxBlockStart on beat 1, rxBlockEnd on beat 8, 16-bit zero-extended data, stall gives rxDataValid=0 with no count advance.
- Gen4: two back-to-back blocks with headers 10 then 11 → rxBlockEnd every 4th beat; rxSyncHdrErr=1 on the 5th beat; rxLocked stays 1.
- Gen5 LOCKED:
  - RxStartBlock=1 at beat_cnt=2 → rxAlignErr=1 and rxBlockStart=1 together; the next rxBlockEnd follows 3 beats later.
  - Missing start at beat_cnt=0 → rxAlignErr=1, then rxLocked=0.
- Gen3 LOCKED mid-block:
  - RxValid drops → rxLocked=0 with no error.
  - generation switches to 4 → UNLOCKED, next data is 32-bit.
  - reset_n asserted mid-block → all outputs 0 immediately.
- With PIPE_RX_ERR_CNT_EN: 300 error events → rxErrCount=255; rxErrCountClr=1 together with an error → 0.
